priority_decoder_q: RTL and testbench

PRIORITY_DECODER_Q -- requirements
Module: priority_decoder_q

---
 rtl/priority_decoder_q.sv | 125 ++++++++++++
 tb/tb_priority_decoder_q.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_decoder_q.sv
// Queued 7-bit priority-index decoder: DEPTH-entry FIFO feeding a registered one-hot
// (and, with PRIDEC_THERMO_EN, thermometer) decode of the head entry, plus a hit counter.
module priority_decoder_q #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_idx,
    input  logic             in_none,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_onehot,
`ifdef PRIDEC_THERMO_EN
    output logic [127:0]     out_thermo,
`endif
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] hit_cnt
);
    localparam int unsigned IDX_W = 7;
    localparam int unsigned DEC_W = 128;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef struct packed {
        logic             none;
        logic [IDX_W-1:0] idx;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [DEC_W-1:0]   onehot_q, onehot_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    entry_t             in_word;
    entry_t             head_d;
    logic               push;
    logic               pop;
`ifdef PRIDEC_THERMO_EN
    logic [DEC_W-1:0]   thermo_q, thermo_d;
`endif

    // Next-state: pointers, occupancy, and the decode of the entry that will be head.
    always_comb begin
        in_word  = '{none: in_none, idx: in_idx};
        push     = in_valid && in_ready_q;
        pop      = out_valid_q && out_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        occ_d       = occ_q + OCC_W'(push) - OCC_W'(pop);
        in_ready_d  = (occ_d != OCC_W'(DEPTH));
        out_valid_d = (occ_d != OCC_W'(0));
        head_d      = mem_d[rd_ptr_d];
        onehot_d    = '0;
        if (out_valid_d && !head_d.none) begin
            onehot_d = DEC_W'(1) << head_d.idx;
        end
`ifdef PRIDEC_THERMO_EN
        // 2<<127 wraps to zero, so the subtraction yields all-ones for idx=127.
        thermo_d = '0;
        if (out_valid_d && !head_d.none) begin
            thermo_d = (DEC_W'(2) << head_d.idx) - DEC_W'(1);
        end
`endif
        hit_cnt_d = hit_cnt_q;
        if (clr_cnt) begin
            hit_cnt_d = '0;
        end else if (push && !in_none && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            onehot_q    <= '0;
            hit_cnt_q   <= '0;
`ifdef PRIDEC_THERMO_EN
            thermo_q    <= '0;
`endif
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            onehot_q    <= onehot_d;
            hit_cnt_q   <= hit_cnt_d;
`ifdef PRIDEC_THERMO_EN
            thermo_q    <= thermo_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_onehot = onehot_q;
    assign hit_cnt    = hit_cnt_q;
`ifdef PRIDEC_THERMO_EN
    assign out_thermo = thermo_q;
`endif

endmodule

// File: tb/tb_priority_decoder_q.sv
// Directed and scoreboard-checked bench for priority_decoder_q (DEPTH=2, CNT_W=4).
module tb_priority_decoder_q;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       in_idx = '0;
    logic             in_none = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [127:0]     out_onehot;
`ifdef PRIDEC_THERMO_EN
    logic [127:0]     out_thermo;
`endif
    logic             clr_cnt = 1'b0;
    logic [CNT_W-1:0] hit_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_hit = 0;

    priority_decoder_q #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_none    (in_none),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
`ifdef PRIDEC_THERMO_EN
        .out_thermo (out_thermo),
`endif
        .clr_cnt    (clr_cnt),
        .hit_cnt    (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        n_tests++;
        if (out_valid !== 1'b0 || out_onehot !== 128'd0 || hit_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state valid=%0b onehot=%h hit=%0d want 0/0/0", out_valid, out_onehot, hit_cnt);
        end
`ifdef PRIDEC_THERMO_EN
        n_tests++;
        if (out_thermo !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_thermo got=%h want 0", out_thermo);
        end
`endif
        step();
        rst_n = 1'b1;
        step();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic;
        in_valid = 1'b1; in_idx = 7'd5; in_none = 1'b0; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        exp_hit = 1;
        n_tests++;
        if (out_valid !== 1'b1 || out_onehot !== 128'h20 || hit_cnt !== CNT_W'(exp_hit)) begin
            n_fail++;
            $display("FAIL basic_idx5 valid=%0b onehot=%h hit=%0d want 1/20/%0d", out_valid, out_onehot, hit_cnt, exp_hit);
        end
`ifdef PRIDEC_THERMO_EN
        n_tests++;
        if (out_thermo !== 128'h3F) begin
            n_fail++;
            $display("FAIL basic_thermo got=%h want 3f", out_thermo);
        end
`endif
        step();
        n_tests++;
        if (out_valid !== 1'b0 || out_onehot !== 128'd0) begin
            n_fail++;
            $display("FAIL basic_drained valid=%0b onehot=%h want 0/0", out_valid, out_onehot);
        end
    endtask

    task automatic test_full;
        logic [127:0] b127;
        b127 = 128'd1 << 127;
        out_ready = 1'b0;
        in_valid = 1'b1; in_idx = 7'd127; in_none = 1'b0;
        step();
        in_idx = 7'd0;
        step();
        in_valid = 1'b0;
        exp_hit = 3;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_onehot !== b127) begin
            n_fail++;
            $display("FAIL full_state in_ready=%0b valid=%0b onehot=%h want 0/1/bit127", in_ready, out_valid, out_onehot);
        end
`ifdef PRIDEC_THERMO_EN
        n_tests++;
        if (out_thermo !== {128{1'b1}}) begin
            n_fail++;
            $display("FAIL full_thermo got=%h want all-ones", out_thermo);
        end
`endif
        step();
        step();
        n_tests++;
        if (out_valid !== 1'b1 || out_onehot !== b127 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_hold valid=%0b onehot=%h in_ready=%0b want 1/bit127/0", out_valid, out_onehot, in_ready);
        end
        // Push offered while full, alongside a pop: must be refused.
        out_ready = 1'b1; in_valid = 1'b1; in_idx = 7'd50;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_onehot !== 128'd1 || in_ready !== 1'b1 || hit_cnt !== CNT_W'(exp_hit)) begin
            n_fail++;
            $display("FAIL full_pop1 valid=%0b onehot=%h in_ready=%0b hit=%0d want 1/1/1/%0d", out_valid, out_onehot, in_ready, hit_cnt, exp_hit);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0 || out_onehot !== 128'd0) begin
            n_fail++;
            $display("FAIL full_no_push valid=%0b onehot=%h want 0/0", out_valid, out_onehot);
        end
    endtask

    task automatic test_none;
        out_ready = 1'b0;
        in_valid = 1'b1; in_idx = 7'd9; in_none = 1'b1;
        step();
        in_valid = 1'b0; in_none = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_onehot !== 128'd0 || hit_cnt !== CNT_W'(exp_hit)) begin
            n_fail++;
            $display("FAIL none_entry valid=%0b onehot=%h hit=%0d want 1/0/%0d", out_valid, out_onehot, hit_cnt, exp_hit);
        end
`ifdef PRIDEC_THERMO_EN
        n_tests++;
        if (out_thermo !== 128'd0) begin
            n_fail++;
            $display("FAIL none_thermo got=%h want 0", out_thermo);
        end
`endif
        out_ready = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL none_drain valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_saturate;
        logic [127:0] e;
        out_ready = 1'b1; in_none = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_idx = 7'(i + 10);
            step();
            e = 128'd1 << (i + 10);
            n_tests++;
            if (out_valid !== 1'b1 || out_onehot !== e || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_%0d valid=%0b onehot=%h in_ready=%0b want 1/%h/1", i, out_valid, out_onehot, in_ready, e);
            end
        end
        exp_hit = 15;
        n_tests++;
        if (hit_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL hit_saturate got=%0d want 15", hit_cnt);
        end
        clr_cnt = 1'b1; in_idx = 7'd3;
        step();
        clr_cnt = 1'b0; in_valid = 1'b0;
        exp_hit = 0;
        n_tests++;
        if (hit_cnt !== 4'd0 || out_onehot !== 128'h8) begin
            n_fail++;
            $display("FAIL clr_priority hit=%0d onehot=%h want 0/8", hit_cnt, out_onehot);
        end
        step();
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0; in_valid = 1'b1; in_none = 1'b0;
        in_idx = 7'd20;
        step();
        in_idx = 7'd21;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0 || hit_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL mid_fill in_ready=%0b hit=%0d want 0/2", in_ready, hit_cnt);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_onehot !== 128'd0 || hit_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_async valid=%0b onehot=%h hit=%0d want 0/0/0", out_valid, out_onehot, hit_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_hit = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_onehot !== 128'd0) begin
                n_fail++;
                $display("FAIL mid_stale_%0d valid=%0b in_ready=%0b onehot=%h want 0/1/0", i, out_valid, in_ready, out_onehot);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]   q[$];
        logic [7:0]   w;
        logic [127:0] e;
        logic         iv;
        logic         orr;
        int           sz;
        for (int c = 0; c < 300; c++) begin
            sz = q.size();
            n_tests++;
            if (out_valid !== (sz != 0) || in_ready !== (sz < int'(DEPTH))) begin
                n_fail++;
                $display("FAIL b2b_flags_c%0d valid=%0b in_ready=%0b occ=%0d", c, out_valid, in_ready, sz);
            end
            iv  = 1'($urandom_range(0, 3) != 0);
            orr = 1'($urandom_range(0, 2) != 0);
            w   = 8'($urandom_range(0, 255));
            w[7] = ($urandom_range(0, 7) == 0);
            in_valid = iv; in_none = w[7]; in_idx = w[6:0]; out_ready = orr;
            if (orr && sz != 0) begin
                e = q[0][7] ? 128'd0 : (128'd1 << q[0][6:0]);
                n_tests++;
                if (out_onehot !== e) begin
                    n_fail++;
                    $display("FAIL b2b_data_c%0d got=%h want=%h", c, out_onehot, e);
                end
                void'(q.pop_front());
            end
            if (iv && sz < int'(DEPTH)) begin
                q.push_back(w);
                if (!w[7] && exp_hit < 15) exp_hit++;
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < int'(DEPTH) + 2; c++) begin
            if (q.size() != 0) begin
                e = q[0][7] ? 128'd0 : (128'd1 << q[0][6:0]);
                n_tests++;
                if (out_valid !== 1'b1 || out_onehot !== e) begin
                    n_fail++;
                    $display("FAIL b2b_drain_%0d valid=%0b got=%h want=%h", c, out_valid, out_onehot, e);
                end
                void'(q.pop_front());
            end
            step();
        end
        n_tests++;
        if (out_valid !== 1'b0 || q.size() != 0 || hit_cnt !== CNT_W'(exp_hit)) begin
            n_fail++;
            $display("FAIL b2b_end valid=%0b left=%0d hit=%0d want 0/0/%0d", out_valid, q.size(), hit_cnt, exp_hit);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_none();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
